// File: rtl/counter_mod.sv
// Up/down modulo-(MAX+1) counter with optional saturation, clock-enable prescaler,
// terminal-count pulse and sticky overflow flag.
module counter_mod #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cout,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0] MAX_X    = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] ONE_X    = (WIDTH+1)'(1);
  localparam logic [8:0]     PRE_LAST = 9'(PRESCALE - 1);

  logic [WIDTH-1:0] r_cnt;
  logic [8:0]       r_pre;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH:0] w_cur;
  logic [WIDTH:0] w_din;
  logic [WIDTH:0] w_next;
  logic           w_pre_wrap;
  logic           w_step;
  logic           w_at_bound;
  logic           w_hold;
  logic           w_tc;
  logic           w_ovf_set;

  always_comb begin
    w_cur      = {1'b0, r_cnt};
    w_din      = {1'b0, din};
    w_pre_wrap = (r_pre == PRE_LAST);
    w_step     = en && !clr && !load && w_pre_wrap;
    w_at_bound = up ? (w_cur == MAX_X) : (w_cur == '0);
    w_hold     = SATURATE && w_at_bound;
    if (up) begin
      w_next = w_at_bound ? (SATURATE ? MAX_X : '0) : (w_cur + ONE_X);
    end else begin
      w_next = w_at_bound ? (SATURATE ? '0 : MAX_X) : (w_cur - ONE_X);
    end
    // A held step at the bound leaves the count unchanged, so it must not re-pulse tc
    w_tc      = w_step && !w_hold && (w_next == (up ? MAX_X : '0));
    w_ovf_set = w_step && w_at_bound;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_pre <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (clr) begin
        r_cnt <= '0;
        r_pre <= '0;
      end else if (load) begin
        r_cnt <= (w_din > MAX_X) ? MAX_X[WIDTH-1:0] : din;
        r_pre <= '0;
      end else if (en) begin
        r_pre <= w_pre_wrap ? '0 : (r_pre + 9'd1);
        if (w_pre_wrap) begin
          r_cnt <= w_next[WIDTH-1:0];
        end
      end
      r_tc <= w_tc;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cout = r_cnt;
  assign tc   = r_tc;
  assign ovf  = r_ovf;

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning count register width in bits (legal 2..32).
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1, meaning the terminal count value (legal 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 0 = wrap at the bounds and 1 = hold at the bounds.
REQ-004 The block SHALL have parameter PRESCALE, default 1, meaning enabled clk cycles per count step (legal 1..256).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-007 The block SHALL have port en, input, 1 bit, count enable.
REQ-008 The block SHALL have port up, input, 1 bit, direction: 1 = increment, 0 = decrement.
REQ-009 The block SHALL have port clr, input, 1 bit, synchronous clear.
REQ-010 The block SHALL have port load, input, 1 bit, synchronous load of din.
REQ-011 The block SHALL have port din, input, WIDTH bits, load value.
REQ-012 The block SHALL have port ovf_clr, input, 1 bit, clears the sticky ovf flag.
REQ-013 The block SHALL have port cout, output, WIDTH bits, current count, registered.
REQ-014 The block SHALL have port tc, output, 1 bit, registered one-cycle pulse on the step that reaches the bound.
REQ-015 The block SHALL have port ovf, output, 1 bit, sticky flag set on a wrap or on a saturated step attempt.

Function
REQ-016 Priority per edge SHALL be clr > load > count step; clr or load SHALL zero the prescaler, and ovf is unaffected by either.
REQ-017 load SHALL write din if din <= MAX, else MAX, with no tc pulse.
REQ-018 The prescaler SHALL advance only on edges with en=1 and no clr/load; a step occurs on the edge where it reaches PRESCALE-1, after which it returns to 0.
REQ-019 With PRESCALE=1 a step SHALL occur on every en=1 edge, so cout changes the edge after en is sampled high (1-cycle latency).
REQ-020 On en=0 the prescaler and cout SHALL hold.
REQ-021 Up step: cout<MAX -> cout+1; cout==MAX -> 0 when SATURATE=0, hold at MAX when SATURATE=1.
REQ-022 Down step: cout>0 -> cout-1; cout==0 -> MAX when SATURATE=0, hold at 0 when SATURATE=1.
REQ-023 tc SHALL be 1 for exactly the cycle after a step whose result equals MAX (up) or 0 (down), including the step that wraps into that value; otherwise 0.
REQ-024 In SATURATE=1, a held step at the bound SHALL NOT re-pulse tc.
REQ-025 ovf SHALL set on any wrap (SATURATE=0) or any step attempted at the bound (SATURATE=1).
REQ-026 ovf_clr SHALL clear ovf; if a set condition occurs on the same edge, set SHALL win.
REQ-027 A change of up SHALL take effect on the next step with no prescaler reset.
REQ-028 Arithmetic SHALL be WIDTH+1 bits internally; cout SHALL never exceed MAX.

Reset
REQ-029 rst=0 SHALL immediately and asynchronously force cout=0, tc=0, ovf=0 and prescaler=0, independent of clk.
REQ-030 A reset mid-count SHALL discard the partial prescale; counting SHALL resume from 0 on the first edge with rst=1 and en=1.
REQ-031 Reset deassertion SHALL be clean for the first edge; the release is synchronised externally.

Verification (WIDTH=4, MAX=9 unless stated)
REQ-032 Reset, then en=1, up=1 for 12 edges -> cout 1..9,0,1,2; tc high the cycle cout=9; ovf=1 after the 9->0 wrap.
REQ-033 SATURATE=1: load din=7, en=1, up=1 for 4 edges -> cout 8,9,9,9; tc once at 9; ovf=1; ovf_clr pulse -> ovf=0.
REQ-034 load din=15 -> cout=9; then up=0 for 11 steps -> 8..0,9,8; tc when cout=0; wrap 0->9 sets ovf.
REQ-035 PRESCALE=3, en=1, up=1 for 9 edges -> cout 0,0,1,1,1,2,2,2,3; en=0 for 5 edges -> cout and prescaler held.
REQ-036 clr and load same edge with din=5 -> cout=0; load and en same edge -> cout=5, no step.
REQ-037 rst=0 asserted mid-cycle at cout=6 -> cout=0 before the next clk edge; ovf_clr and set same edge -> ovf=1.
